// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sevenseg_scan_ctrl: multiplexed common-anode 7-seg scanner, double-buffer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] load_data_i,
  input  logic [NUM_DIGITS-1:0]   load_dp_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic                    lz_blank_i,
  input  logic                    disp_off_i,
  output logic [3:0]              digit_val_o,
  output logic                    digit_dp_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic                    frame_start_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] C_GUARD      = PW'(GUARD);
  localparam logic [IW-1:0] C_IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]                presc_q, presc_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0][3:0]   pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]        act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]        pend_dp_q, pend_dp_d;
  logic                         pend_full_q, pend_full_d;
  logic [3:0]                   digit_val_q, digit_val_d;
  logic                         digit_dp_q, digit_dp_d;
  logic [NUM_DIGITS-1:0]        digit_en_q, digit_en_d;
  logic                         frame_start_q, frame_start_d;

  logic w_slot_wrap;
  logic w_frame_wrap;
  logic w_xfer;
  logic w_upper_zero;
  logic w_lead_blank;

  assign w_slot_wrap  = (presc_q == C_PRESC_LAST);
  assign w_frame_wrap = w_slot_wrap && (idx_q == C_IDX_LAST);
  assign w_xfer       = load_valid_i && !pend_full_q;

  // Scan counters and the pending -> active double buffer.
  always_comb begin
    presc_d     = w_slot_wrap ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (w_slot_wrap) begin
      idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (w_frame_wrap && pend_full_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
    // Only possible while pending is empty, so it never collides with the apply.
    if (w_xfer) begin
      pend_data_d = load_data_i;
      pend_dp_d   = load_dp_i;
      pend_full_d = 1'b1;
    end
  end

  // The current digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IW'(i) >= idx_q) && (act_data_q[i] != 4'd0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign w_lead_blank = lz_blank_i && (idx_q != '0) && w_upper_zero && !act_dp_q[idx_q];

  always_comb begin
    digit_val_d   = act_data_q[idx_q];
    digit_dp_d    = act_dp_q[idx_q];
    digit_en_d    = '0;
    frame_start_d = (presc_q == '0) && (idx_q == '0);
    if ((presc_q >= C_GUARD) && !disp_off_i && !w_lead_blank) begin
      digit_en_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_full_q   <= 1'b0;
      digit_val_q   <= '0;
      digit_dp_q    <= 1'b0;
      digit_en_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_full_q   <= pend_full_d;
      digit_val_q   <= digit_val_d;
      digit_dp_q    <= digit_dp_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready_o  = !pend_full_q;
  assign digit_val_o   = digit_val_q;
  assign digit_dp_o    = digit_dp_q;
  assign digit_en_o    = digit_en_q;
  assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sevenseg_scan_ctrl: scan, handshake, apply, blanking and reset checks  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sevenseg_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] load_data_i = '0;
  logic [3:0]  load_dp_i = '0;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic        lz_blank_i = 1'b0;
  logic        disp_off_i = 1'b0;
  logic [3:0]  digit_val_o;
  logic        digit_dp_o;
  logic [3:0]  digit_en_o;
  logic        frame_start_o;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_data_i  (load_data_i),
    .load_dp_i    (load_dp_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .lz_blank_i   (lz_blank_i),
    .disp_off_i   (disp_off_i),
    .digit_val_o  (digit_val_o),
    .digit_dp_o   (digit_dp_o),
    .digit_en_o   (digit_en_o),
    .frame_start_o(frame_start_o)
  );

  typedef struct packed {
    logic [3:0] val;
    logic       dp;
    logic [3:0] en;
    logic       fs;
    logic       rdy;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic        off;
    logic [15:0] en;
    logic [15:0] val;
    logic [3:0]  dps;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;

  // Reference state: mk counts clock edges since reset release.
  int          mk;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_adp, m_pdp;
  logic        m_full;

  // Per-slot snapshot taken mid-slot (anode window), used for frame-level checks.
  logic [15:0] obs_en, obs_val;
  logic [3:0]  obs_dp;
  int          fs_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    mk = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_full = 1'b0;
    sbq.delete();
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   p, i;
    logic blank;
    p = mk % RD;
    i = (mk / RD) % ND;
    e.val = m_act[i*4 +: 4];
    e.dp  = m_adp[i];
    blank = 1'b0;
    if (lz_blank_i && i > 0) begin
      blank = !m_adp[i];
      for (int j = i; j < ND; j++) if (m_act[j*4 +: 4] != 4'd0) blank = 1'b0;
    end
    e.en  = (p >= GD && !disp_off_i && !blank) ? 4'(1 << i) : 4'd0;
    e.fs  = (mk % FR == 0);
    e.rdy = 1'b1;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    logic wrap, xfer;
    int   pre, slot;
    e    = model_out();
    pre  = mk;
    wrap = (mk % FR == FR - 1);
    xfer = load_valid_i && !m_full;
    if (wrap && m_full) begin m_act = m_pend; m_adp = m_pdp; m_full = 1'b0; end
    if (xfer) begin m_pend = load_data_i; m_pdp = load_dp_i; m_full = 1'b1; end
    mk++;
    e.rdy = !m_full;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("digit_val", digit_val_o, e.val);
    chk("digit_dp", digit_dp_o, e.dp);
    chk("digit_en", digit_en_o, e.en);
    chk("frame_start", frame_start_o, e.fs);
    chk("load_ready", load_ready_o, e.rdy);
    if (frame_start_o) fs_count++;
    if (pre % RD == RD / 2) begin
      slot = (pre / RD) % ND;
      obs_en[slot*4 +: 4]  = digit_en_o;
      obs_val[slot*4 +: 4] = digit_val_o;
      obs_dp[slot]         = digit_dp_o;
    end
  endtask

  task automatic run_frame();
    do tick(); while (mk % FR != 0);
  endtask

  task automatic run_until(input int phase);
    while (mk % FR != phase) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    int   budget;
    logic acc;
    budget = 100;
    load_data_i = d; load_dp_i = dp; load_valid_i = 1'b1;
    forever begin
      acc = load_ready_o;
      tick();
      if (acc) break;
      budget--;
      if (budget == 0) begin chk("load_timeout", 0, 1); break; end
    end
    load_valid_i = 1'b0;
  endtask

  initial begin
    int acc_pre, budget;
    tbl[0] = '{16'h0007, 4'b0000, 1'b1, 1'b0, 16'h0001, 16'h0007, 4'b0000};
    tbl[1] = '{16'h0007, 4'b0100, 1'b1, 1'b0, 16'h0401, 16'h0007, 4'b0100};
    tbl[2] = '{16'h0007, 4'b0100, 1'b1, 1'b1, 16'h0000, 16'h0007, 4'b0100};
    tbl[3] = '{16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0001, 16'h0000, 4'b0000};
    tbl[4] = '{16'h0000, 4'b0000, 1'b0, 1'b0, 16'h8421, 16'h0000, 4'b0000};
    tbl[5] = '{16'h0000, 4'b1010, 1'b1, 1'b0, 16'h8021, 16'h0000, 4'b1010};
    tbl[6] = '{16'h0070, 4'b0000, 1'b1, 1'b0, 16'h0021, 16'h0070, 4'b0000};
    tbl[7] = '{16'h1A3F, 4'b0000, 1'b1, 1'b0, 16'h8421, 16'h1A3F, 4'b0000};
    obs_en = '0; obs_val = '0; obs_dp = '0; fs_count = 0;
    model_reset();

    // Reset state, then free-running scan with no load.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_val", digit_val_o, 0);
    chk("rst_en", digit_en_o, 0);
    chk("rst_fs", frame_start_o, 0);
    chk("rst_ready", load_ready_o, 1);
    rst = 1'b0;
    model_reset();
    repeat (2 * FR) tick();
    chk("scan_fs_count", fs_count, 2);
    chk("scan_en_slots", obs_en, 16'h8421);
    chk("scan_val_slots", obs_val, 16'h0000);

    // Mid-frame load, then backpressure on a second load held until accepted.
    run_until(10);
    do_load(16'h1A3F, 4'b0000);
    chk("ready_drop", load_ready_o, 0);
    load_data_i = 16'h0042; load_dp_i = 4'b0000; load_valid_i = 1'b1;
    acc_pre = -1;
    budget = 2 * FR;
    while (budget > 0) begin
      if (load_ready_o) begin
        chk("old_until_frame", digit_val_o, 0);
        acc_pre = mk;
        tick();
        break;
      end
      tick();
      budget--;
    end
    load_valid_i = 1'b0;
    chk("bp_accept_phase", acc_pre % FR, 0);
    run_frame();
    chk("apply_val_slots", obs_val, 16'h1A3F);
    chk("apply_en_slots", obs_en, 16'h8421);
    run_frame();
    chk("bp_show_val", obs_val, 16'h0042);

    // Transfer on the frame-wrap cycle lands one frame later.
    run_until(FR - 1);
    load_data_i = 16'h5555; load_dp_i = 4'b0000; load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    chk("simul_captured", load_ready_o, 0);
    run_frame();
    chk("simul_old_frame", obs_val, 16'h0042);
    run_frame();
    chk("simul_new_frame", obs_val, 16'h5555);
    chk("simul_ready_back", load_ready_o, 1);

    // Blanking / disp_off table.
    for (int n = 0; n < 8; n++) begin
      lz_blank_i = tbl[n].lz;
      disp_off_i = tbl[n].off;
      do_load(tbl[n].data, tbl[n].dp);
      run_frame();
      fs_count = 0;
      run_frame();
      chk($sformatf("tbl%0d_en", n), obs_en, tbl[n].en);
      chk($sformatf("tbl%0d_val", n), obs_val, tbl[n].val);
      chk($sformatf("tbl%0d_dp", n), obs_dp, tbl[n].dps);
      chk($sformatf("tbl%0d_fs", n), fs_count, 1);
    end

    // Asynchronous reset in slot 2 with pending full.
    lz_blank_i = 1'b0;
    disp_off_i = 1'b0;
    do_load(16'h1234, 4'b1111);
    run_until(20);
    chk("pre_rst_en", digit_en_o, 4'b0100);
    chk("pre_rst_val", digit_val_o, 4'hA);
    #3 rst = 1'b1;
    #1;
    chk("async_en", digit_en_o, 0);
    chk("async_val", digit_val_o, 0);
    chk("async_dp", digit_dp_o, 0);
    chk("async_ready", load_ready_o, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_frame();
    run_frame();
    chk("post_rst_val", obs_val, 16'h0000);
    chk("post_rst_dp", obs_dp, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
